// File: rtl/logical_tile_io_po_extmode_ccff.sv
// Output pad tile with a serially loaded local config chain.
// Ports: clk, reset, config_enable/ccff_head/ccff_tail (config chain),
// io_po_io_po_outpad (fabric data), gfpga_pad_poutput_extmode_F2A and
// gfpga_pad_poutput_extmode_mode_o (to SoC), cfg_done, cfg_err (status).
module logical_tile_io_po_extmode_ccff #(
  parameter int   NUM_CFG  = 3,
  parameter logic SAFE_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic config_enable,
  input  logic ccff_head,
  output logic ccff_tail,
  input  logic io_po_io_po_outpad,
  output logic gfpga_pad_poutput_extmode_F2A,
  output logic gfpga_pad_poutput_extmode_mode_o,
  output logic cfg_done,
  output logic cfg_err
);

  localparam int CW = $clog2(NUM_CFG + 1);

  typedef enum logic [1:0] {
    UNCFG,
    SHIFT,
    DONE
  } state_t;

  state_t             state;
  logic [NUM_CFG-1:0] cfg_sr;
  logic [CW-1:0]      cnt;
  logic               pipe;

  logic mode_en;
  logic reg_en;
  logic invert;
  logic d;

  assign mode_en = cfg_sr[0];
  assign reg_en  = cfg_sr[1];
  assign invert  = cfg_sr[2];
  assign d       = io_po_io_po_outpad ^ invert;

  // Unregistered bypass only once a load is locked.
  assign gfpga_pad_poutput_extmode_F2A =
    (state == DONE) ? (reg_en ? pipe : d) : SAFE_VAL;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= UNCFG;
      cfg_sr    <= '0;
      cnt       <= '0;
      pipe      <= SAFE_VAL;
      ccff_tail <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      gfpga_pad_poutput_extmode_mode_o <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      pipe    <= config_enable ? SAFE_VAL : d;
      if (config_enable) begin
        cfg_sr    <= {cfg_sr[NUM_CFG-2:0], ccff_head};
        ccff_tail <= cfg_sr[NUM_CFG-1];
        state     <= SHIFT;
        cfg_done  <= 1'b0;
        gfpga_pad_poutput_extmode_mode_o <= 1'b0;
        // A new load always restarts the count at the first shift.
        if (state == SHIFT) begin
          if (cnt != CW'(NUM_CFG)) begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= CW'(1);
        end
      end else begin
        unique case (state)
          SHIFT: begin
            if (cnt == CW'(NUM_CFG)) begin
              state    <= DONE;
              cfg_done <= 1'b1;
              gfpga_pad_poutput_extmode_mode_o <= mode_en;
            end else begin
              state   <= UNCFG;
              cfg_err <= 1'b1;
            end
          end
          UNCFG: state <= UNCFG;
          DONE:  state <= DONE;
          default: state <= UNCFG;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_logical_tile_io_po_extmode_ccff.sv
// Bench for logical_tile_io_po_extmode_ccff: directed table,
// hand sequences and random traffic against a history-based model.
module tb_logical_tile_io_po_extmode_ccff;

  localparam int NUM_CFG = 3;

  logic clk = 1'b0;
  logic reset, config_enable, ccff_head, outpad;
  logic ccff_tail, f2a, mode_o, cfg_done, cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logical_tile_io_po_extmode_ccff #(
    .NUM_CFG (NUM_CFG),
    .SAFE_VAL(1'b0)
  ) dut (
    .clk                              (clk),
    .reset                            (reset),
    .config_enable                    (config_enable),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .io_po_io_po_outpad               (outpad),
    .gfpga_pad_poutput_extmode_F2A    (f2a),
    .gfpga_pad_poutput_extmode_mode_o (mode_o),
    .cfg_done                         (cfg_done),
    .cfg_err                          (cfg_err)
  );

  typedef struct {
    logic rst, en, head, o;
    logic f2a, mode, done, err, tail;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic head, logic o,
                              logic ef, logic em, logic ed, logic ee,
                              logic et);
    vec_t v;
    v.rst = rst; v.en = en; v.head = head; v.o = o;
    v.f2a = ef; v.mode = em; v.done = ed; v.err = ee; v.tail = et;
    return v;
  endfunction

  task automatic chk(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle; outputs are then sampled 1 ns later.
  task automatic step(logic rst, logic en, logic head, logic o);
    @(negedge clk);
    reset = rst; config_enable = en; ccff_head = head; outpad = o;
    #1;
  endtask

  task automatic chk_all(string tag, logic ef, logic em, logic ed,
                         logic ee, logic et);
    chk({tag, ".f2a"}, f2a, ef);
    chk({tag, ".mode"}, mode_o, em);
    chk({tag, ".done"}, cfg_done, ed);
    chk({tag, ".err"}, cfg_err, ee);
    chk({tag, ".tail"}, ccff_tail, et);
  endtask

  // Reference model: history of every bit shifted since reset.
  bit hist[$];
  bit m_cfg, m_shift, m_err, m_pipe, m_mode, m_tail;
  int m_run;

  function automatic bit cbit(int i);
    if (hist.size() > i) return hist[hist.size() - 1 - i];
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_cfg = 0; m_shift = 0; m_err = 0; m_pipe = 0;
    m_mode = 0; m_tail = 0; m_run = 0;
  endtask

  task automatic model_check(string tag);
    bit ef;
    bit d;
    d  = outpad ^ cbit(2);
    ef = m_cfg ? (cbit(1) ? m_pipe : d) : 1'b0;
    chk_all(tag, ef, m_cfg ? m_mode : 1'b0, m_cfg, m_err, m_tail);
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else if (config_enable) begin
      m_tail = cbit(NUM_CFG - 1);
      hist.push_back(ccff_head);
      m_run   = m_shift ? ((m_run < NUM_CFG) ? m_run + 1 : NUM_CFG) : 1;
      m_shift = 1; m_cfg = 0; m_err = 0; m_pipe = 0;
    end else begin
      m_pipe = outpad ^ cbit(2);
      m_err  = m_shift && (m_run < NUM_CFG);
      if (m_shift && m_run == NUM_CFG) begin
        m_cfg  = 1;
        m_mode = cbit(0);
      end
      m_shift = 0;
    end
  endtask

  initial begin
    int burst_left;
    bit burst_en;
    reset = 1; config_enable = 0; ccff_head = 0; outpad = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);

    // reset hold with outpad toggling
    tbl.push_back(mk(1,0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,0));
    // load 1,0,1: inverted, combinational, mode on
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,1,0,0));
    tbl.push_back(mk(0,0,0,1, 0,1,1,0,0));
    // load 0,1,0: registered, non-inverted
    tbl.push_back(mk(0,1,0,0, 1,1,1,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,1, 0,0,1,0,1));
    tbl.push_back(mk(0,0,0,1, 1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0, 1,0,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,1,0,1));
    // short load of 2 bits
    tbl.push_back(mk(0,1,1,0, 0,0,1,0,1));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0,1));
    // reset beats config_enable, then 5-bit load 1,1,0,1,1
    tbl.push_back(mk(1,1,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0,1));
    tbl.push_back(mk(0,0,0,0, 1,1,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,1,1,0,1));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].head, tbl[i].o);
      chk_all($sformatf("vec%0d", i), tbl[i].f2a, tbl[i].mode,
              tbl[i].done, tbl[i].err, tbl[i].tail);
    end

    // reconfigure from DONE with pipe=1, then reset mid-shift
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    step(0, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reld.f2a", f2a, 1'b1);
    chk("reld.done", cfg_done, 1'b1);
    step(0, 1, 1, 1);
    chk("reld.hold_f2a", f2a, 1'b1);
    step(0, 1, 1, 1);
    chk("reld.safe_f2a", f2a, 1'b0);
    chk("reld.safe_done", cfg_done, 1'b0);
    chk("reld.safe_mode", mode_o, 1'b0);
    step(1, 1, 1, 1);
    step(0, 0, 0, 1);
    chk("rstmid.err0", cfg_err, 1'b0);
    step(0, 0, 0, 1);
    chk("rstmid.err1", cfg_err, 1'b0);
    chk("rstmid.done", cfg_done, 1'b0);
    chk("rstmid.f2a", f2a, 1'b0);

    // random traffic against the model
    step(1, 0, 0, 0);
    model_reset();
    burst_left = 0;
    burst_en = 0;
    for (int c = 0; c < 3000; c++) begin
      if (burst_left == 0) begin
        burst_en = !burst_en;
        burst_left = burst_en ? $urandom_range(1, 6) : $urandom_range(1, 5);
      end
      burst_left--;
      step(($urandom % 150) == 0, burst_en, 1'($urandom),
           1'($urandom));
      model_check($sformatf("rnd%0d", c));
      model_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
